// File: rtl/console_pkg.sv
// Shared types and constants for the console output stage.
// Imported by the serialiser top and its byte FIFO.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam logic       IDLE_LEVEL = 1'b1;
    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_NUL  = 8'h00;

    function automatic logic is_newline(input logic [7:0] b);
        return (b == ASCII_NL);
    endfunction

endpackage

// File: rtl/console_tx_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy count.
// Count is one bit wider than the pointers so full and empty are distinct.
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [7:0]       i_din,
    input  logic             i_pop,
    output logic [7:0]       o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/console_tx.sv
// Console output stage: filters NUL bytes, buffers characters and
// serialises them as 8N1 frames, pulsing line_done after each newline frame.
module console_tx
    import console_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int CLKS_PER_BIT = 4,
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic [PTR_W:0]   fifo_count,
    output logic             line_done,
    output logic             dropped_null
);

    localparam int               TMR_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state;
    logic [7:0]       r_sh;
    logic [2:0]       r_bit_idx;
    logic [TMR_W-1:0] r_timer;
    logic             r_is_nl;
    logic             r_tx;
    logic             r_line_done;
    logic             r_dropped;

    tx_state_t        w_state_nxt;
    logic [7:0]       w_sh_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_is_nl_nxt;
    logic             w_line_done_nxt;
    logic             w_tx_nxt;
    logic             w_pop;
    logic             w_accept;
    logic             w_is_null;
    logic             w_push;
    logic             w_timer_zero;
    logic [7:0]       w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [PTR_W:0]   w_fifo_count;

    assign w_accept     = char_valid && char_ready;
    assign w_is_null    = (char_in == ASCII_NUL);
    assign w_push       = w_accept && !w_is_null;
    assign w_timer_zero = (r_timer == '0);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (char_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign char_ready   = !w_fifo_full;
    assign fifo_count   = w_fifo_count;
    assign tx_busy      = (r_state != IDLE) || (w_fifo_count != '0);
    assign tx           = r_tx;
    assign line_done    = r_line_done;
    assign dropped_null = r_dropped;

    // Serialiser next-state: each phase holds for CLKS_PER_BIT cycles.
    always_comb begin
        w_state_nxt     = r_state;
        w_sh_nxt        = r_sh;
        w_bit_idx_nxt   = r_bit_idx;
        w_timer_nxt     = r_timer;
        w_is_nl_nxt     = r_is_nl;
        w_line_done_nxt = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_head;
                    w_is_nl_nxt = is_newline(w_head);
                    w_timer_nxt = TMR_LOAD;
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_timer_zero) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_timer_nxt   = TMR_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            DATA: begin
                if (w_timer_zero) begin
                    w_timer_nxt = TMR_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_sh_nxt      = {1'b0, r_sh[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            STOP: begin
                if (w_timer_zero) begin
                    w_state_nxt     = IDLE;
                    w_line_done_nxt = r_is_nl;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered so tx changes with the state.
    always_comb begin
        case (w_state_nxt)
            START:   w_tx_nxt = START_BIT;
            DATA:    w_tx_nxt = w_sh_nxt[0];
            STOP:    w_tx_nxt = STOP_BIT;
            default: w_tx_nxt = IDLE_LEVEL;
        endcase
    end

    // State, datapath and output pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sh        <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_timer     <= '0;
            r_is_nl     <= 1'b0;
            r_tx        <= IDLE_LEVEL;
            r_line_done <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh        <= w_sh_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_timer     <= w_timer_nxt;
            r_is_nl     <= w_is_nl_nxt;
            r_tx        <= w_tx_nxt;
            r_line_done <= w_line_done_nxt;
            r_dropped   <= w_accept && w_is_null;
        end
    end

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx: vector table for reset/handshake/null
// behaviour, hand sequences for frame timing, full FIFO and mid-frame reset.
module tb_console_tx;

    localparam int DEPTH = 16;
    localparam int CPB   = 4;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       tx;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       line_done;
    logic       dropped_null;

    console_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count),
        .line_done    (line_done),
        .dropped_null (dropped_null)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference queue of bytes expected on the line, and a line monitor.
    logic [7:0] sb[$];
    int         start_q[$];
    int         cyc        = 0;
    int         ln_count   = 0;
    int         ln_cycle   = 0;
    int         drop_count = 0;
    int         rx_count   = 0;
    bit         in_frame   = 0;
    int         t          = 0;
    logic [7:0] rx;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_frame = 0;
            sb.delete();
        end else begin
            if (line_done) begin ln_count++; ln_cycle = cyc; end
            if (dropped_null) drop_count++;
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame = 1;
                    t = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                t++;
                if (t >= 6 && t <= 34 && ((t - 6) % 4) == 0) rx[(t - 6) / 4] = tx;
                if (t == 38) chk("stop_bit", {31'd0, tx}, 32'd1);
                if (t == 39) begin
                    in_frame = 0;
                    rx_count++;
                    if (sb.size() == 0) chk("unexpected_frame", {24'd0, rx}, 32'h100);
                    else chk("rx_byte", {24'd0, rx}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    int waits, cacc;

    task automatic send(input logic [7:0] b, output int w, output int c_acc);
        logic rdy;
        int   c;
        bit   ok;
        char_in = b; char_valid = 1'b1; w = 0; c_acc = -1; ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rdy = char_ready;
            c = int'(fifo_count);
            @(posedge clk);
            if (rdy) begin
                c_acc = c;
                ok = 1;
                if (b != 8'h00) sb.push_back(b);
                break;
            end
            w++;
        end
        #1;
        char_valid = 1'b0; char_in = 8'h00;
        chk("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send1(input logic [7:0] b);
        int w, c;
        send(b, w, c);
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!tx_busy) begin ok = 1; break; end
        end
        chk("drain", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] ch;
        logic       e_rdy;
        logic [4:0] e_cnt;
        logic       e_tx;
        logic       e_busy;
        logic       e_drop;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, l0, lows;
        logic rdy_b;
        logic e_tx;

        vt[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'h61, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b1, 8'h62, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; char_valid = 1'b0; char_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, NUL filtering between 0x61 and 0x62, first-frame start.
        d0 = drop_count; r0 = rx_count;
        for (int i = 0; i < 7; i++) begin
            reset = vt[i].rst; char_valid = vt[i].vld; char_in = vt[i].ch;
            @(negedge clk);
            rdy_b = char_ready;
            @(posedge clk);
            if (!vt[i].rst && vt[i].vld && rdy_b && vt[i].ch != 8'h00) sb.push_back(vt[i].ch);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, char_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_count", i), {27'd0, fifo_count}, {27'd0, vt[i].e_cnt});
            chk($sformatf("v%0d_tx", i), {31'd0, tx}, {31'd0, vt[i].e_tx});
            chk($sformatf("v%0d_busy", i), {31'd0, tx_busy}, {31'd0, vt[i].e_busy});
            chk($sformatf("v%0d_drop", i), {31'd0, dropped_null}, {31'd0, vt[i].e_drop});
            chk($sformatf("v%0d_line", i), {31'd0, line_done}, 32'd0);
        end
        char_valid = 1'b0; char_in = 8'h00;
        wait_idle(300);
        chk("null_drop_pulses", drop_count - d0, 32'd2);
        chk("null_frames", rx_count - r0, 32'd2);

        // Single 0x41 frame, cycle-exact waveform.
        send1(8'h41);
        chk("a_count", {27'd0, fifo_count}, 32'd1);
        chk("a_tx0", {31'd0, tx}, 32'd1);
        for (int j = 1; j <= 41; j++) begin
            @(posedge clk); #1;
            if (j <= 4) e_tx = 1'b0;
            else if (j <= 36) e_tx = ((8'h41 >> ((j - 5) / 4)) & 8'h01) != 8'h00;
            else e_tx = 1'b1;
            chk($sformatf("a_tx_j%0d", j), {31'd0, tx}, {31'd0, e_tx});
            if (j >= 40) chk($sformatf("a_busy_j%0d", j), {31'd0, tx_busy}, (j == 40) ? 32'd1 : 32'd0);
        end

        // Burst "Hi\n": one idle cycle between frames, single line_done.
        wait_idle(100);
        start_q.delete(); l0 = ln_count;
        send1(8'h48); chk("hi_count1", {27'd0, fifo_count}, 32'd1);
        send1(8'h69); chk("hi_pushpop_count1", {27'd0, fifo_count}, 32'd1);
        send1(8'h0A); chk("hi_count2", {27'd0, fifo_count}, 32'd2);
        wait_idle(300);
        chk("hi_frames", start_q.size(), 32'd3);
        chk("hi_gap1", start_q[1] - start_q[0], 32'd41);
        chk("hi_gap2", start_q[2] - start_q[1], 32'd41);
        chk("hi_line_pulses", ln_count - l0, 32'd1);
        chk("hi_line_cycle", ln_cycle, start_q[2] + 40);

        // Fill to DEPTH while a frame is on the line; 17th byte is held.
        r0 = rx_count;
        send1(8'h5A);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send1(8'h80 + 8'(i));
        chk("full_count", {27'd0, fifo_count}, 32'd16);
        chk("full_ready", {31'd0, char_ready}, 32'd0);
        send(8'h90, waits, cacc);
        chk("held_waited", (waits > 0) ? 32'd1 : 32'd0, 32'd1);
        chk("held_after_pop", cacc, 32'd15);
        chk("held_count", {27'd0, fifo_count}, 32'd16);
        wait_idle(2000);
        chk("fill_frames", rx_count - r0, 32'd18);

        // Reset during DATA bit 3 of 0x55 with five bytes queued.
        l0 = ln_count;
        send1(8'h55);
        send1(8'h0A); send1(8'h31); send1(8'h0A); send1(8'h32); send1(8'h33);
        chk("rst_pre_count", {27'd0, fifo_count}, 32'd5);
        repeat (13) @(posedge clk);
        #1;
        chk("rst_pre_bit3", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_ready", {31'd0, char_ready}, 32'd1);
        reset = 1'b0;
        lows = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        chk("rst_tx_idle", lows, 32'd0);
        chk("rst_no_line", ln_count - l0, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/console_tx.md
Name: console_tx

Overview:
Console output stage directly downstream of the string printer. Accepts ASCII bytes over a valid/ready handshake and buffers them in a FIFO. Serialises each byte onto a single 8N1 UART-style line so printed strings reach a synthesizable console instead of simulator $write. Flags each transmitted newline so the testbench and debug logic can count complete lines.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CLKS_PER_BIT, 4, clock cycles per serial bit; minimum 2
PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
char_in  in  8  ASCII byte from printer
char_valid  in  1  char_in is valid this cycle
char_ready  out  1  FIFO can accept a byte this cycle
tx  out  1  serial output; idle high
tx_busy  out  1  frame in progress or FIFO non-empty
fifo_count  out  PTR_W+1  bytes currently buffered
line_done  out  1  one-cycle pulse when the stop bit of a 0x0A frame completes
dropped_null  out  1  one-cycle pulse when an accepted 0x00 is discarded

Behaviour:
- Reset: one clock, synchronous, active-high. Values after the reset edge:
  - tx=1, tx_busy=0, fifo_count=0, char_ready=1, line_done=0, dropped_null=0.
  - FSM=IDLE; pointers, bit counter and timer cleared.
- Reset mid-frame: the frame is aborted and tx=1 from the next edge. FIFO contents are lost. No line_done is issued.
- Handshake:
  - A byte is accepted on a rising edge when char_valid && char_ready.
  - char_ready = (fifo_count != DEPTH). It is computed from the registered count only and does not look ahead at a same-cycle pop.
- Null bytes: an accepted 0x00 is not enqueued and dropped_null pulses on the following cycle. Nulls are never transmitted.
- Simultaneous push and pop in one cycle: both take effect and fifo_count is unchanged.
- Full: char_ready=0 and a valid byte is held by the producer (no loss).
- Empty: no pop occurs and the FSM stays in IDLE.
- Pointers wrap modulo DEPTH. Count uses PTR_W+1 bits to distinguish full from empty.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop the head into shift register sh, go to START next cycle, and load timer=CLKS_PER_BIT-1.
  - START: tx=0 for CLKS_PER_BIT cycles. At timer==0 go to DATA with bit_idx=0.
  - DATA: tx=sh[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then sh shifts right. After bit_idx==7 expires, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On expiry return to IDLE and pulse line_done if the frame byte was 0x0A.
  - In IDLE, a pop may happen in the same cycle STOP returns, so back-to-back frames have exactly one IDLE cycle between stop and start.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE:
  - cycle N accept;
  - N+1 count=1, pop;
  - N+2 tx falls (START).
- Frame length: exactly 10*CLKS_PER_BIT cycles of START+DATA+STOP.
- tx is registered and glitch-free.
- tx_busy = (state != IDLE) || (fifo_count != 0).

Decomposition:
- Shared package console_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, STOP)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - ASCII_NL=8'h0A, ASCII_NUL=8'h00
- One sub-module, byte_fifo:
  - Synchronous single-clock FIFO with push, pop, full, empty and count.
  - Parameterised by DEPTH, with the same clk/reset.
- console_tx instantiates byte_fifo and contains the null filter, the serialiser FSM and the line_done logic.

Test Plan:
- Reset then a single byte 0x41, CLKS_PER_BIT=4:
  - tx low at accept+2 for 4 cycles;
  - data bits 1,0,0,0,0,0,1,0, 4 cycles each;
  - high stop for 4 cycles;
  - tx_busy drops 1 cycle after stop ends.
- Burst "Hi\n" (0x48,0x69,0x0A) on consecutive cycles:
  - three frames separated by exactly one idle cycle each;
  - line_done pulses once, at the end of the third frame;
  - fifo_count peaks at 2 or 3 as predicted.
- Fill with 17 bytes while tx is stalled mid-frame, DEPTH=16:
  - char_ready=0 when count=16;
  - the 17th byte is held and accepted the cycle after the next pop;
  - no byte is lost or duplicated.
- Push 0x00 between 0x61 and 0x62:
  - dropped_null pulses once;
  - only 0x61 and 0x62 frames appear on tx.
- Assert reset during DATA bit 3 of 0x55 with 5 bytes queued:
  - tx=1, fifo_count=0, tx_busy=0 next cycle;
  - no line_done.
- Push and pop in the same cycle with count=1:
  - count stays 1;
  - FIFO order is preserved, checked with a scoreboard against a reference queue.
